// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the ALU issue pipeline.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 2;
  localparam int NREG  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_issue_pipe_if.sv
// Command, load, external-ALU and writeback signals of alu_issue_pipe.
// slave = the pipeline, master = the parent that drives commands and hosts the ALU.
interface alu_issue_pipe_if import alu_pkg::*; #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREG  = alu_pkg::NREG
) ();

  localparam int AW = $clog2(NREG);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [AW-1:0]   cmd_rs1;
  logic [AW-1:0]   cmd_rs2;
  logic [AW-1:0]   cmd_rd;

  logic            ld_valid;
  logic [AW-1:0]   ld_addr;
  logic [WIDTH-1:0] ld_data;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_i0;
  logic [WIDTH-1:0] alu_i1;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout;

  logic             res_valid;
  logic [AW-1:0]    res_rd;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    input  ld_valid, ld_addr, ld_data,
    input  alu_o, alu_cout,
    output cmd_ready, alu_op, alu_i0, alu_i1,
    output res_valid, res_rd, res_data, res_cout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    output ld_valid, ld_addr, ld_data,
    output alu_o, alu_cout,
    input  cmd_ready, alu_op, alu_i0, alu_i1,
    input  res_valid, res_rd, res_data, res_cout
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one clocked write stage where a
// writeback beats an external load on the same entry. Synchronous clear on reset.
module alu_regfile import alu_pkg::*; #(
  parameter  int WIDTH = alu_pkg::WIDTH,
  parameter  int NREG  = alu_pkg::NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    i_rs1,
  input  logic [AW-1:0]    i_rs2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_ld_en,
  input  logic [AW-1:0]    i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data
);

  logic [WIDTH-1:0] r_mem [NREG];
  logic [NREG-1:0]  w_sel_wb;
  logic [NREG-1:0]  w_sel_ld;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_sel_wb = '0;
    w_sel_ld = '0;
    if (i_wb_en) w_sel_wb[i_wb_addr] = 1'b1;
    if (i_ld_en) w_sel_ld[i_ld_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is small and must read back zero after reset, so it lives in
      // flops with an explicit clear rather than in a RAM macro without reset.
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_sel_wb[i])      r_mem[i] <= i_wb_data;
        else if (w_sel_ld[i]) r_mem[i] <= i_ld_data;
      end
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not visible yet.
  assign o_rd1 = r_mem[i_rs1];
  assign o_rd2 = r_mem[i_rs2];

endmodule

// File: rtl/alu_issue_pipe.sv
// Two-stage issue pipeline (EX operand registers, WB report) around an external ALU.
// Define ALU_ISSUE_FWD_EN to forward alu_o on a read-after-write hazard instead of stalling.
module alu_issue_pipe import alu_pkg::*; #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREG  = alu_pkg::NREG
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_pipe_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_op0;
  logic [WIDTH-1:0] w_op1;
  logic             w_hit0;
  logic             w_hit1;
  logic             w_stall;
  logic             w_ready;
  logic             w_accept;

  logic             r_ex_valid;
  logic [AW-1:0]    r_ex_rd;
  logic [OP_W-1:0]  r_alu_op;
  logic [WIDTH-1:0] r_alu_i0;
  logic [WIDTH-1:0] r_alu_i1;

  logic             r_res_valid;
  logic [AW-1:0]    r_res_rd;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_cout;

  alu_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_rs1     (bus.cmd_rs1),
    .i_rs2     (bus.cmd_rs2),
    .o_rd1     (w_rd0),
    .o_rd2     (w_rd1),
    .i_wb_en   (r_ex_valid),
    .i_wb_addr (r_ex_rd),
    .i_wb_data (bus.alu_o),
    .i_ld_en   (bus.ld_valid),
    .i_ld_addr (bus.ld_addr),
    .i_ld_data (bus.ld_data)
  );

  // The EX command has not written rd yet, so a source that names it is stale.
  assign w_hit0 = r_ex_valid && (r_ex_rd == bus.cmd_rs1);
  assign w_hit1 = r_ex_valid && (r_ex_rd == bus.cmd_rs2);

`ifdef ALU_ISSUE_FWD_EN
  assign w_stall = 1'b0;
  assign w_op0   = w_hit0 ? bus.alu_o : w_rd0;
  assign w_op1   = w_hit1 ? bus.alu_o : w_rd1;
`else
  assign w_stall = w_hit0 || w_hit1;
  assign w_op0   = w_rd0;
  assign w_op1   = w_rd1;
`endif

  assign w_ready  = !reset && !bus.ld_valid && !w_stall;
  assign w_accept = bus.cmd_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_alu_op    <= '0;
      r_alu_i0    <= '0;
      r_alu_i1    <= '0;
      r_res_valid <= 1'b0;
      r_res_rd    <= '0;
      r_res_data  <= '0;
      r_res_cout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the pre-edge value of the
      // stage before it, which is what makes EX and WB a real two-deep pipeline.
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_rd  <= bus.cmd_rd;
        r_alu_op <= bus.cmd_op;
        r_alu_i0 <= w_op0;
        r_alu_i1 <= w_op1;
      end
      r_res_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_res_rd   <= r_ex_rd;
        r_res_data <= bus.alu_o;
        r_res_cout <= bus.alu_cout;
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_i0    = r_alu_i0;
  assign bus.alu_i1    = r_alu_i1;
  assign bus.res_valid = r_res_valid;
  assign bus.res_rd    = r_res_rd;
  assign bus.res_data  = r_res_data;
  assign bus.res_cout  = r_res_cout;

endmodule

// File: doc/alu_issue_pipe.md
ALU_ISSUE_PIPE -- requirements
Module: alu_issue_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL match the ALU operand width.
REQ-002 Parameter NREG, default 8, register-file depth; address width AW = clog2(NREG).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  ALU opcode, passed through unchanged.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  input  AW each  source and destination register indices.
REQ-009 ld_valid, ld_addr, ld_data  input  1/AW/WIDTH  external register load port.
REQ-010 alu_op, alu_i0, alu_i1  output  2/WIDTH/WIDTH  registered operands driving the external alu.
REQ-011 alu_o, alu_cout  input  WIDTH/1  combinational ALU result.
REQ-012 res_valid, res_rd, res_data, res_cout  output  1/AW/WIDTH/1  registered writeback report.

Function
REQ-013 Pipeline SHALL be two stages: EX (alu_* registers plus ex_valid and ex_rd) and WB (res_* registers).
REQ-014 On acceptance in cycle N, the block SHALL read rs1/rs2 and drive alu_op/alu_i0/alu_i1 from cycle N+1.
REQ-015 At the end of cycle N+1, the block SHALL write alu_o into register rd and raise res_valid for exactly cycle N+2.
REQ-016 res_rd, res_data and res_cout SHALL hold their last values while res_valid=0.
REQ-017 When no command is accepted, ex_valid SHALL clear, and alu_* SHALL hold their previous values.
REQ-018 Hazard: if ex_valid=1 and ex_rd equals cmd_rs1 or cmd_rs2, the pipeline SHALL handle it as defined in REQ-026/REQ-027.
REQ-019 cmd_ready SHALL be 0 whenever ld_valid=1; load has priority over command issue.
REQ-020 If a writeback and ld_valid target the same register in the same cycle, the writeback SHALL win.
REQ-021 A register read in the same cycle as a load to that register SHALL return the old value.
REQ-022 rs1 == rs2 == rd SHALL be legal; the register SHALL update only at writeback.

Reset
REQ-023 Reset SHALL clear every register-file entry, ex_valid, alu_op, alu_i0, alu_i1, res_valid, res_rd, res_data and res_cout to 0.
REQ-024 cmd_ready SHALL be 0 while reset=1.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight EX command with no writeback, and res_valid SHALL be 0 in the following cycle.

Configuration
REQ-026 With macro ALU_ISSUE_FWD_EN defined, a REQ-018 hazard SHALL not stall; the matching operand SHALL be taken from alu_o, and cmd_ready SHALL stay 1.
REQ-027 Without ALU_ISSUE_FWD_EN, a REQ-018 hazard SHALL drive cmd_ready=0 for one cycle, and the command SHALL issue the next cycle with the written-back value.

Structure
REQ-028 Package alu_pkg SHALL hold WIDTH, the opcode width (2), the NREG default and the opcode constants (2'b00 add, 2'b01 subtract, 2'b10 and, 2'b11 or).
REQ-029 Sub-module alu_regfile SHALL implement the register file: 2 asynchronous read ports, 1 synchronous write port, write-select muxing for WB/load and the reset clear.
REQ-030 The external alu SHALL be instantiated only in the bench and the parent, never inside alu_issue_pipe.

Verification
REQ-031 Load r1=16'haa55, r2=16'h55aa; issue add rd=r3 -> alu_i0=aa55 and alu_i1=55aa at N+1; res_valid at N+2 with res_data=ffff, res_cout=0.
REQ-032 Load r1=16'hffff, r2=16'h0001; add rd=r4 -> res_data=0000, res_cout=1, r4 reads 0000.
REQ-033 Issue add r5=r1+r2, then next cycle r6=r5+r2 -> without FWD_EN cmd_ready=0 for exactly one cycle; with FWD_EN no stall, and both builds give r6=r5+1.
REQ-034 Hold cmd_valid and ld_valid high together -> cmd_ready=0 until ld_valid drops; load to rd concurrent with writeback -> writeback value retained.
REQ-035 Assert reset in the cycle after acceptance -> no res_valid, all outputs 0, registers 0.
